// File: rtl/red_pitaya_mult_arbiter_pkg.sv
// Shared definitions for the multiplier-lane arbiter: register offsets,
// arbitration mode encodings and the fixed pipeline latency.
package red_pitaya_mult_arbiter_pkg;

  localparam logic [15:0] REG_MASK      = 16'h0100;
  localparam logic [15:0] REG_MODE      = 16'h0104;
  localparam logic [15:0] REG_GCNT      = 16'h0108;
  localparam logic [15:0] REG_CLR       = 16'h010C;
  localparam logic [15:0] REG_STAT_BASE = 16'h0110;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } arb_mode_e;

  localparam int MULT_ARB_LAT = 3;

endpackage

// File: rtl/red_pitaya_mult_arbiter_lane.sv
// Shared 3-stage signed multiply / scale / saturate lane. The valid and
// requester-ID tags travel alongside the data so results leave in issue order.
module mult_arb_lane
  import red_pitaya_mult_arbiter_pkg::*;
#(
  parameter int DW  = 14,
  parameter int IDW = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic [IDW-1:0]       in_id_i,
  input  logic signed [DW-1:0] in_a_i,
  input  logic signed [DW-1:0] in_b_i,
  output logic                 res_valid_o,
  output logic [IDW-1:0]       res_id_o,
  output logic signed [DW-1:0] res_dat_o
);

  localparam logic signed [2*DW-1:0] SAT_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] SAT_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Q(DW-1) rescale: arithmetic shift, then clamp to the DW-bit signed range.
  function automatic logic signed [DW-1:0] scale_sat(input logic signed [2*DW-1:0] prod);
    logic signed [2*DW-1:0] shifted;
    shifted = prod >>> (DW-1);
    if (shifted > SAT_MAX) begin
      scale_sat = SAT_MAX[DW-1:0];
    end else if (shifted < SAT_MIN) begin
      scale_sat = SAT_MIN[DW-1:0];
    end else begin
      scale_sat = shifted[DW-1:0];
    end
  endfunction

  logic                   v0_q, v1_q;
  logic [IDW-1:0]         id0_q, id1_q;
  logic signed [DW-1:0]   a0_q, b0_q;
  logic signed [2*DW-1:0] prod_d, prod_q;

  assign prod_d = {{DW{a0_q[DW-1]}}, a0_q} * {{DW{b0_q[DW-1]}}, b0_q};

  // Stages S0 (operand capture), S1 (product) and S2 (scaled result, held when idle).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v0_q        <= 1'b0;
      id0_q       <= '0;
      a0_q        <= '0;
      b0_q        <= '0;
      v1_q        <= 1'b0;
      id1_q       <= '0;
      prod_q      <= '0;
      res_valid_o <= 1'b0;
      res_id_o    <= '0;
      res_dat_o   <= '0;
    end else begin
      v0_q        <= in_valid_i;
      id0_q       <= in_id_i;
      a0_q        <= in_a_i;
      b0_q        <= in_b_i;
      v1_q        <= v0_q;
      id1_q       <= id0_q;
      prod_q      <= prod_d;
      res_valid_o <= v1_q;
      if (v1_q) begin
        res_id_o  <= id1_q;
        res_dat_o <= scale_sat(prod_q);
      end else begin
        res_id_o  <= res_id_o;
        res_dat_o <= res_dat_o;
      end
    end
  end

endmodule

// File: rtl/red_pitaya_mult_arbiter.sv
// Arbiter sharing one multiplier lane between NREQ requesters, configured over
// the PS register bus. Define MULT_ARB_STATS_EN for per-requester grant counters.
module red_pitaya_mult_arbiter
  import red_pitaya_mult_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int DW   = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*DW-1:0]   req_a_i,
  input  logic [NREQ*DW-1:0]   req_b_i,
  output logic                 res_valid_o,
  output logic [IDW-1:0]       res_id_o,
  output logic signed [DW-1:0] res_dat_o,
  input  logic [15:0]          addr,
  input  logic                 wen,
  input  logic                 ren,
  output logic                 ack,
  output logic [31:0]          rdata,
  input  logic [31:0]          wdata
);

  logic [NREQ-1:0]      mask_q;
  arb_mode_e            mode_q;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [31:0]          gcnt_q, gcnt_d;
  logic                 ack_q;
  logic [31:0]          rdata_q, rd_val_s;
  logic [NREQ-1:0]      elig_s, gnt_s;
  logic                 gnt_any_s;
  logic [IDW-1:0]       gnt_id_s;
  logic signed [DW-1:0] sel_a_s, sel_b_s;
  logic                 wr_mask_s, wr_mode_s, clr_s;
  logic                 unused_s;

  assign elig_s = req_valid_i & mask_q;

  // Grant search; iterating from the far end lets the first match in search order win.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_any_s = 1'b0;
    gnt_id_s  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (mode_q == MODE_FIXED) begin
        idx = k;
      end else begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        else             idx = idx;
      end
      if (elig_s[idx[IDW-1:0]]) begin
        gnt_any_s = 1'b1;
        gnt_id_s  = idx[IDW-1:0];
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // One-hot grant vector and next round-robin pointer.
  always_comb begin
    gnt_s           = '0;
    gnt_s[gnt_id_s] = gnt_any_s;
    if (gnt_any_s && (mode_q == MODE_RR)) begin
      ptr_d = (int'(gnt_id_s) == NREQ - 1) ? '0 : gnt_id_s + 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  assign req_ready_o = rst_i ? '0 : gnt_s;
  assign sel_a_s     = req_a_i[gnt_id_s*DW +: DW];
  assign sel_b_s     = req_b_i[gnt_id_s*DW +: DW];

  assign wr_mask_s = wen && (addr == REG_MASK);
  assign wr_mode_s = wen && (addr == REG_MODE);
`ifdef MULT_ARB_STATS_EN
  assign clr_s = wen && (addr == REG_CLR);
`else
  assign clr_s = 1'b0;
`endif
  assign gcnt_d   = clr_s ? 32'h0 : gcnt_q + {31'b0, gnt_any_s};
  assign unused_s = ^wdata;

`ifdef MULT_ARB_STATS_EN
  logic [31:0] stat_q [NREQ];

  // Per-requester grant counters; a clear wins over a same-cycle grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= 32'h0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (clr_s)                             stat_q[i] <= 32'h0;
        else if (gnt_any_s && (gnt_id_s == i)) stat_q[i] <= stat_q[i] + 32'd1;
        else                                   stat_q[i] <= stat_q[i];
      end
    end
  end
`endif

  // Register read mux; anything unmapped reads as zero.
  always_comb begin
    case (addr)
      REG_MASK: rd_val_s = {{(32-NREQ){1'b0}}, mask_q};
      REG_MODE: rd_val_s = {31'b0, logic'(mode_q)};
      REG_GCNT: rd_val_s = gcnt_q;
      default:  rd_val_s = 32'h0;
    endcase
`ifdef MULT_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      if (addr == REG_STAT_BASE + 16'(4 * i)) rd_val_s = stat_q[i];
      else                                    rd_val_s = rd_val_s;
    end
`endif
  end

  // Arbitration state and total grant counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      gcnt_q <= 32'h0;
    end else begin
      ptr_q  <= ptr_d;
      gcnt_q <= gcnt_d;
    end
  end

  // Bus-side registers; config writes land after the cycle that carries them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q  <= {NREQ{1'b1}};
      mode_q  <= MODE_RR;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ack_q <= wen | ren;
      if (ren)       rdata_q <= rd_val_s;
      else           rdata_q <= rdata_q;
      if (wr_mask_s) mask_q  <= wdata[NREQ-1:0];
      else           mask_q  <= mask_q;
      if (wr_mode_s) mode_q  <= arb_mode_e'(wdata[0]);
      else           mode_q  <= mode_q;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

  mult_arb_lane #(
    .DW  (DW),
    .IDW (IDW)
  ) u_lane (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (gnt_any_s),
    .in_id_i     (gnt_id_s),
    .in_a_i      (sel_a_s),
    .in_b_i      (sel_b_s),
    .res_valid_o (res_valid_o),
    .res_id_o    (res_id_o),
    .res_dat_o   (res_dat_o)
  );

endmodule

// File: tb/tb_red_pitaya_mult_arbiter.sv
// Self-checking bench for red_pitaya_mult_arbiter: directed scenarios plus
// random traffic against a transaction-level reference model.
module tb_red_pitaya_mult_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 14;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*DW-1:0]   req_a, req_b;
  logic                 res_valid_o;
  logic [IDW-1:0]       res_id_o;
  logic signed [DW-1:0] res_dat_o;
  logic [15:0]          addr;
  logic                 wen, ren, ack;
  logic [31:0]          rdata, wdata;

  red_pitaya_mult_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_a_i(req_a), .req_b_i(req_b),
    .res_valid_o(res_valid_o), .res_id_o(res_id_o), .res_dat_o(res_dat_o),
    .addr(addr), .wen(wen), .ren(ren), .ack(ack), .rdata(rdata), .wdata(wdata)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int id; int dat; } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  exp_t        exp_q[$];
  logic [3:0]  m_mask;
  int          m_mode, m_ptr, m_cyc;
  int unsigned m_total;
  int unsigned m_stat[NREQ];
  logic        m_ack, m_rd;
  int          m_rdata, m_last_id, m_last_dat, last_ready;
  int          op_a[NREQ], op_b[NREQ];

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_mul(input int a, input int b);
    longint p, q;
    p = longint'(a) * longint'(b);
    q = p / 8192;
    if (p < 0 && (p % 8192) != 0) q = q - 1;
    if (q > 8191)  q = 8191;
    if (q < -8192) q = -8192;
    return int'(q);
  endfunction

  // Winner = eligible requester at the smallest distance from the search start.
  function automatic int model_grant(input logic [3:0] v);
    int best, bestd, d;
    best = -1; bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && m_mask[i]) begin
        d = (m_mode == 1) ? i : (i - m_ptr + NREQ) % NREQ;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  function automatic int model_read(input logic [15:0] a);
    if (a == 16'h0100) return int'(m_mask);
    if (a == 16'h0104) return m_mode;
    if (a == 16'h0108) return int'(m_total);
`ifdef MULT_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) if (a == 16'h0110 + 16'(4*i)) return int'(m_stat[i]);
`endif
    return 0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_mask = 4'hF; m_mode = 0; m_ptr = 0; m_total = 0;
    for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    m_ack = 1'b0; m_rd = 1'b0; m_rdata = 0; m_last_id = 0; m_last_dat = 0;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = op_a[i][DW-1:0];
      req_b[i*DW +: DW] = op_b[i][DW-1:0];
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    int g, rv;
    logic clr;
    @(negedge clk);
    chk_eq("ack", int'(ack), int'(m_ack));
    if (m_rd) chk_eq("rdata", int'(rdata), m_rdata);
    if (exp_q.size() > 0 && exp_q[0].due == m_cyc) begin
      chk_eq("res_valid", int'(res_valid_o), 1);
      chk_eq("res_id", int'(res_id_o), exp_q[0].id);
      chk_eq("res_dat", int'(res_dat_o), exp_q[0].dat);
      m_last_id  = exp_q[0].id;
      m_last_dat = exp_q[0].dat;
      void'(exp_q.pop_front());
    end else begin
      chk_eq("res_valid_idle", int'(res_valid_o), 0);
      chk_eq("res_id_hold", int'(res_id_o), m_last_id);
      chk_eq("res_dat_hold", int'(res_dat_o), m_last_dat);
    end
    g = model_grant(req_valid);
    chk_eq("ready", int'(req_ready_o), (g >= 0) ? (1 << g) : 0);
    last_ready = int'(req_ready_o);
    @(posedge clk);
    rv = model_read(addr);
    clr = 1'b0;
`ifdef MULT_ARB_STATS_EN
    clr = wen && (addr == 16'h010C);
`endif
    m_ack = wen | ren;
    m_rd  = ren;
    if (ren) m_rdata = rv;
    if (g >= 0) begin
      exp_q.push_back('{m_cyc + 3, g, model_mul(op_a[g], op_b[g])});
      if (m_mode == 0) m_ptr = (g + 1) % NREQ;
      if (!clr) begin m_total++; m_stat[g]++; end
    end
    if (clr) begin
      m_total = 0;
      for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    end
    if (wen && addr == 16'h0100) m_mask = wdata[3:0];
    if (wen && addr == 16'h0104) m_mode = int'(wdata[0]);
    m_cyc++;
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    step();
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output int v);
    addr = a; ren = 1'b1;
    step();
    ren = 1'b0;
    v = int'(rdata);
  endtask

  task automatic single_op(input int id, input int a, input int b, input int exp, input string tag);
    req_valid = '0;
    op_a[id] = a; op_b[id] = b; drive_ops();
    req_valid[id] = 1'b1;
    step();
    req_valid = '0;
    step();
    step();
    chk_eq({tag, "_valid"}, int'(res_valid_o), 1);
    chk_eq({tag, "_id"}, int'(res_id_o), id);
    chk_eq({tag, "_dat"}, int'(res_dat_o), exp);
    step();
  endtask

  initial begin
    int v;
    int rr_exp[5] = '{1, 2, 4, 8, 1};
    int edge_v[4] = '{-8192, 8191, 0, -1};
    rst_i = 1'b1; req_valid = 4'hF; addr = '0; wen = 1'b0; ren = 1'b0; wdata = '0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = 100 * (i + 1); op_b[i] = 4096; end
    drive_ops();
    model_reset();
    m_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_ready", int'(req_ready_o), 0);
    chk_eq("rst_res_valid", int'(res_valid_o), 0);
    chk_eq("rst_res_id", int'(res_id_o), 0);
    chk_eq("rst_res_dat", int'(res_dat_o), 0);
    chk_eq("rst_ack", int'(ack), 0);
    chk_eq("rst_rdata", int'(rdata), 0);
    rst_i = 1'b0;

    // Round-robin sweep with everyone requesting
    for (int i = 0; i < 5; i++) begin
      step();
      chk_eq("rr_order", last_ready, rr_exp[i]);
    end
    req_valid = '0;
    repeat (4) step();

    single_op(2, 4096, 4096, 2048, "half");
    single_op(0, -8192, -8192, 8191, "sat_pos");
    single_op(1, 8191, -8192, -8191, "sat_neg");

    // Fixed priority starves requester 3 until requester 1 is masked off
    req_valid = 4'b1010;
    bus_write(16'h0104, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("fixed_prio", last_ready, 2);
    end
    bus_write(16'h0100, 32'hD);
    chk_eq("mask_wr_cycle", last_ready, 2);
    step();
    chk_eq("mask_takes_effect", last_ready, 8);
    step();
    chk_eq("mask_holds", last_ready, 8);
    req_valid = '0;
    bus_write(16'h0104, 32'd0);
    bus_write(16'h0100, 32'hF);
    repeat (4) step();

`ifdef MULT_ARB_STATS_EN
    bus_write(16'h010C, 32'd0);
    req_valid = 4'b0001; repeat (5) step();
    req_valid = 4'b0010; repeat (2) step();
    req_valid = '0;
    bus_read(16'h0110, v); chk_eq("stat0", v, 5);
    bus_read(16'h0114, v); chk_eq("stat1", v, 2);
    bus_read(16'h0108, v); chk_eq("gcnt7", v, 7);
    bus_write(16'h010C, 32'hFFFF_FFFF);
    bus_read(16'h0110, v); chk_eq("stat0_clr", v, 0);
    bus_read(16'h0114, v); chk_eq("stat1_clr", v, 0);
    bus_read(16'h0108, v); chk_eq("gcnt_clr", v, 0);
`else
    bus_read(16'h0110, v); chk_eq("stat_unmapped", v, 0);
    bus_write(16'h010C, 32'd1);
`endif

    // Random traffic with occasional register accesses
    for (int n = 0; n < 1500; n++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          op_a[i] = edge_v[$urandom_range(0, 3)];
          op_b[i] = edge_v[$urandom_range(0, 3)];
        end else begin
          op_a[i] = $urandom_range(0, 16383) - 8192;
          op_b[i] = $urandom_range(0, 16383) - 8192;
        end
      end
      drive_ops();
      case ($urandom_range(0, 39))
        0: bus_write(16'h0100, 32'($urandom_range(0, 15)));
        1: bus_write(16'h0104, 32'($urandom_range(0, 1)));
        2: bus_read(16'h0108, v);
        3: bus_read(16'h0100 + 16'(4 * $urandom_range(0, 7)), v);
        4: bus_write(16'h0108, 32'h1234);
        5: bus_read(16'h0200, v);
        default: step();
      endcase
    end

    // Reset in the middle of back-to-back operations drops everything in flight
    bus_write(16'h0104, 32'd0);
    bus_write(16'h0100, 32'hF);
    req_valid = 4'b0001;
    step();
    step();
    #3 rst_i = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("mid_rst_valid", int'(res_valid_o), 0);
      chk_eq("mid_rst_ready", int'(req_ready_o), 0);
    end
    req_valid = '0;
    @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (6) step();
    bus_read(16'h0100, v); chk_eq("post_rst_mask", v, 15);
    bus_read(16'h0108, v); chk_eq("post_rst_gcnt", v, 0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
